// File: rtl/prog_delay_line.sv
// prog_delay_line: RAM-based programmable delay line with CH time-interleaved channels.
// Optional feature macro PRB_RUNSUM_EN adds a per-channel running-sum output (sum_out).
module prog_delay_line #(
  parameter int SIG_WIDTH = 16,
  parameter int MAX_DEPTH = 512,
  parameter int CH        = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clr,
  input  logic                                   in_valid,
  input  logic [SIG_WIDTH-1:0]                   in_data,
  input  logic [$clog2(MAX_DEPTH):0]             len_in,
  input  logic                                   len_load,
  output logic                                   out_valid,
  output logic [SIG_WIDTH-1:0]                   out_data,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
  output logic                                   primed
`ifdef PRB_RUNSUM_EN
  ,
  output logic [SIG_WIDTH+$clog2(MAX_DEPTH)-1:0] sum_out
`endif
);

  localparam int AW  = $clog2(MAX_DEPTH);
  localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int RAW = $clog2(CH * MAX_DEPTH);
  localparam logic [AW:0]   LEN_MAX = (AW+1)'(MAX_DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);

  logic [AW-1:0] wptr_reg;
  logic [CW-1:0] ch_cnt_reg;
  logic [AW:0]   fill_reg;
  logic [AW:0]   len_reg;
  logic [AW:0]   pend_len_reg;
  logic          pend_reg;
  logic          data_ok_reg;

  logic           apply;
  logic           accept;
  logic           ch_last;
  logic [AW:0]    len_eff;
  logic [AW:0]    fill_eff;
  logic [AW:0]    fill_next;
  logic [AW-1:0]  rptr;
  logic [RAW-1:0] waddr;
  logic [RAW-1:0] raddr;

  function automatic logic [AW:0] clamp_len(input logic [AW:0] v);
    if (v == '0)
      return LEN_ONE;
    else if (v > LEN_MAX)
      return LEN_MAX;
    else
      return v;
  endfunction

  // A pending length takes over at a frame boundary; the same sample already sees it.
  assign apply    = pend_reg && (ch_cnt_reg == '0) && !clr;
  assign accept   = in_valid && !clr;
  assign ch_last  = (ch_cnt_reg == CH_LAST);
  assign len_eff  = apply ? pend_len_reg : len_reg;
  assign fill_eff = apply ? '0 : fill_reg;
  assign rptr     = wptr_reg - len_eff[AW-1:0];
  assign waddr    = RAW'({ch_cnt_reg, wptr_reg});
  assign raddr    = RAW'({ch_cnt_reg, rptr});

  always_comb begin
    fill_next = fill_eff;
    if (in_valid && ch_last && (fill_eff != LEN_MAX))
      fill_next = fill_eff + LEN_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg     <= '0;
      ch_cnt_reg   <= '0;
      fill_reg     <= '0;
      len_reg      <= LEN_MAX;
      pend_len_reg <= LEN_MAX;
      pend_reg     <= 1'b0;
      data_ok_reg  <= 1'b0;
      out_valid    <= 1'b0;
      out_ch       <= '0;
    end else if (clr) begin
      wptr_reg    <= '0;
      ch_cnt_reg  <= '0;
      fill_reg    <= '0;
      pend_reg    <= 1'b0;
      data_ok_reg <= 1'b0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      if (len_load)
        len_reg <= clamp_len(len_in);
    end else begin
      if (apply)
        len_reg <= pend_len_reg;
      if (len_load) begin
        pend_len_reg <= clamp_len(len_in);
        pend_reg     <= 1'b1;
      end else if (apply) begin
        pend_reg <= 1'b0;
      end
      fill_reg    <= fill_next;
      out_valid   <= in_valid;
      data_ok_reg <= in_valid && (fill_eff >= len_eff);
      if (in_valid) begin
        out_ch <= ch_cnt_reg;
        if (ch_last) begin
          ch_cnt_reg <= '0;
          wptr_reg   <= wptr_reg + AW'(1);
        end else begin
          ch_cnt_reg <= ch_cnt_reg + CW'(1);
        end
      end
    end
  end

  // Sample storage; at len=MAX_DEPTH the read hits the written word and returns the old one.
  logic [SIG_WIDTH-1:0] mem [0:CH*MAX_DEPTH-1];
  logic [SIG_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[waddr] <= in_data;
      rd_q       <= mem[raddr];
    end
  end

  assign out_data = data_ok_reg ? rd_q : '0;
  assign primed   = (fill_reg >= len_reg);

`ifdef PRB_RUNSUM_EN
  localparam int SW = SIG_WIDTH + AW;

  logic [SIG_WIDTH-1:0] in_q_reg;
  logic [SW-1:0]        acc_reg [CH];
  logic [SW-1:0]        sum_now;

  // Window sum: previous sum + newest sample - sample leaving the window (0 while unprimed).
  assign sum_now = acc_reg[out_ch]
                 + {{AW{in_q_reg[SIG_WIDTH-1]}}, in_q_reg}
                 - {{AW{out_data[SIG_WIDTH-1]}}, out_data};
  assign sum_out = out_valid ? sum_now : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      in_q_reg <= '0;
    else if (accept)
      in_q_reg <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++)
        acc_reg[i] <= '0;
    end else if (clr || apply) begin
      for (int i = 0; i < CH; i++)
        acc_reg[i] <= '0;
    end else if (out_valid) begin
      acc_reg[out_ch] <= sum_now;
    end
  end
`endif

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: one CH=1 and one CH=2 instance, checked against
// a behavioural per-channel history model (sum_out checked when PRB_RUNSUM_EN is defined).
module tb_prog_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, clr1, iv1, ld1, ov1, primed1;
  logic [15:0] id1, od1;
  logic [9:0]  li1;
  logic [0:0]  oc1;
  logic        rst2, clr2, iv2, ld2, ov2, primed2;
  logic [15:0] id2, od2;
  logic [9:0]  li2;
  logic [0:0]  oc2;
`ifdef PRB_RUNSUM_EN
  logic [24:0] sum1, sum2;
`endif

  prog_delay_line #(.SIG_WIDTH(16), .MAX_DEPTH(512), .CH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .clr(clr1), .in_valid(iv1), .in_data(id1),
    .len_in(li1), .len_load(ld1), .out_valid(ov1), .out_data(od1),
    .out_ch(oc1), .primed(primed1)
`ifdef PRB_RUNSUM_EN
    , .sum_out(sum1)
`endif
  );

  prog_delay_line #(.SIG_WIDTH(16), .MAX_DEPTH(512), .CH(2)) u_dut2 (
    .clk(clk), .rst(rst2), .clr(clr2), .in_valid(iv2), .in_data(id2),
    .len_in(li2), .len_load(ld2), .out_valid(ov2), .out_data(od2),
    .out_ch(oc2), .primed(primed2)
`ifdef PRB_RUNSUM_EN
    , .sum_out(sum2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(string tag, longint got, longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: per-channel history since the last flush.
  int mch [2];
  int len_m [2];
  int pend_m [2];
  bit pflag [2];
  int hcnt [2][2];
  int hbuf [2][2][1024];
  int exp_q0 [$];
  int sq0 [$];
  int exp_q1 [$];
  int sq1 [$];

  function automatic int clampl(int v);
    if (v == 0) return 1;
    if (v > 512) return 512;
    return v;
  endfunction

  task automatic model_flush(int k);
    for (int c = 0; c < 2; c++) hcnt[k][c] = 0;
  endtask

  task automatic model_reset(int k);
    model_flush(k);
    mch[k] = 0; len_m[k] = 512; pend_m[k] = 512; pflag[k] = 0;
    if (k == 0) begin exp_q0.delete(); sq0.delete(); end
    else begin exp_q1.delete(); sq1.delete(); end
  endtask

  task automatic model_edge(int k, bit v, int d, bit c, bit ld, int lin);
    bit ap;
    int ch, n, e, s, lo;
    if (c) begin
      model_flush(k);
      mch[k] = 0;
      pflag[k] = 0;
      if (ld) len_m[k] = clampl(lin);
      return;
    end
    ap = pflag[k] && (mch[k] == 0);
    if (ap) begin len_m[k] = pend_m[k]; model_flush(k); end
    if (ld) begin pend_m[k] = clampl(lin); pflag[k] = 1; end
    else if (ap) pflag[k] = 0;
    if (v) begin
      ch = mch[k];
      n = hcnt[k][ch];
      e = (n >= len_m[k]) ? hbuf[k][ch][(n - len_m[k]) % 1024] : 0;
      hbuf[k][ch][n % 1024] = d;
      hcnt[k][ch] = n + 1;
      s = 0;
      lo = (n + 1 > len_m[k]) ? n + 1 - len_m[k] : 0;
      for (int j = lo; j <= n; j++) s += hbuf[k][ch][j % 1024];
      if (k == 0) begin
        exp_q0.push_back(e & 16'hFFFF);
        sq0.push_back(s);
      end else begin
        exp_q1.push_back((ch << 16) | (e & 16'hFFFF));
        sq1.push_back(s);
      end
      mch[k] = (mch[k] == k) ? 0 : mch[k] + 1;
    end
  endtask

  // One clock: model both DUTs for the edge, advance, drop pulses, check primed.
  task automatic edge_go();
    if (!rst1) model_edge(0, iv1, int'($signed(id1)), clr1, ld1, int'(li1));
    if (!rst2) model_edge(1, iv2, int'($signed(id2)), clr2, ld2, int'(li2));
    @(posedge clk);
    #1;
    ld1 = 0; ld2 = 0; clr1 = 0; clr2 = 0;
    if (!rst1) check_eq("primed1", primed1, (hcnt[0][0] >= len_m[0]) ? 1 : 0);
    if (!rst2) check_eq("primed2", primed2, (hcnt[1][1] >= len_m[1]) ? 1 : 0);
  endtask

  task automatic send1(bit v, int d);
    iv1 = v; id1 = 16'(d);
    edge_go();
    iv1 = 0;
  endtask

  task automatic send2(bit v, int d);
    iv2 = v; id2 = 16'(d);
    edge_go();
    iv2 = 0;
  endtask

  task automatic load1(int l);
    li1 = 10'(l); ld1 = 1;
  endtask

  task automatic load2(int l);
    li2 = 10'(l); ld2 = 1;
  endtask

  always @(negedge clk) begin
    int e1, s1;
    if (ov1) begin
      if (exp_q0.size() == 0) begin
        check_eq("extra_out1", 1, 0);
      end else begin
        e1 = exp_q0.pop_front();
        s1 = sq0.pop_front();
        $display("dut1 out data=%0d exp=%0d sum_model=%0d", od1, e1, s1);
        check_eq("data1", od1, e1);
`ifdef PRB_RUNSUM_EN
        check_eq("sum1", $signed(sum1), s1);
`endif
      end
    end
  end

  always @(negedge clk) begin
    int e2, s2;
    if (ov2) begin
      if (exp_q1.size() == 0) begin
        check_eq("extra_out2", 1, 0);
      end else begin
        e2 = exp_q1.pop_front();
        s2 = sq1.pop_front();
        $display("dut2 out ch=%0d data=%0d exp_ch=%0d exp=%0d", oc2, od2, e2 >> 16, e2 & 16'hFFFF);
        check_eq("ch_data2", (int'(oc2) << 16) | int'(od2), e2);
`ifdef PRB_RUNSUM_EN
        check_eq("sum2", $signed(sum2), s2);
`endif
      end
    end
  end

  initial begin
    rst1 = 1; clr1 = 0; iv1 = 0; id1 = '0; ld1 = 0; li1 = '0;
    rst2 = 1; clr2 = 0; iv2 = 0; id2 = '0; ld2 = 0; li2 = '0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid1", ov1, 0);
    check_eq("rst_data1", od1, 0);
    check_eq("rst_primed1", primed1, 0);
    check_eq("rst_valid2", ov2, 0);
    check_eq("rst_ch2", oc2, 0);
    check_eq("rst_primed2", primed2, 0);
    rst1 = 0; rst2 = 0;

    // T1: len_in=0 clamps to 1, continuous ramp
    load1(0); edge_go(); edge_go();
    for (int n = 1; n <= 10; n++) send1(1, n);
    edge_go(); edge_go();

    // T2: len=8 ramp, primed rises with the 8th sample
    load1(8); edge_go(); edge_go();
    for (int n = 1; n <= 20; n++) send1(1, n);
    edge_go(); edge_go();

    // T4: len_in above MAX clamps to 512, gapped random stream across pointer wrap
    load1(600); edge_go(); edge_go();
    for (int i = 0; i < 3000; i++) send1(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)));
    edge_go(); edge_go();

    // T3: CH=2, len=4 interleaved channels
    load2(4); edge_go(); edge_go();
    for (int n = 1; n <= 8; n++) begin send2(1, 100 + n); send2(1, 200 + n); end
    edge_go(); edge_go();

    // T5: len 8 -> 5 -> 3 loaded mid-frame; applies at the next channel-0 sample
    load2(8); edge_go(); edge_go();
    for (int n = 1; n <= 10; n++) begin send2(1, 300 + n); send2(1, 400 + n); end
    send2(1, 311);
    load2(5); edge_go();
    load2(3); edge_go();
    send2(1, 411);
    for (int n = 12; n <= 20; n++) begin send2(1, 300 + n); send2(1, 400 + n); end
    edge_go(); edge_go();

    // T6: reset mid-stream, then clr with a dropped sample, then clr together with len_load
    for (int n = 1; n <= 6; n++) send1(1, 1000 + n);
    rst1 = 1;
    #1;
    check_eq("rst_async_valid1", ov1, 0);
    check_eq("rst_async_data1", od1, 0);
    model_reset(0);
    edge_go(); edge_go();
    rst1 = 0;
    load1(2); edge_go(); edge_go();
    for (int n = 1; n <= 5; n++) send1(1, 2000 + n);
    clr1 = 1; iv1 = 1; id1 = 16'd9999;
    edge_go();
    iv1 = 0;
    for (int n = 1; n <= 4; n++) send1(1, 3000 + n);
    clr1 = 1; load1(3); edge_go();
    for (int n = 1; n <= 6; n++) send1(1, 4000 + n);
    edge_go(); edge_go();

    // T7: len=4 constant streams, including full-scale negative samples
    load1(4); edge_go(); edge_go();
    for (int n = 0; n < 8; n++) send1(1, 100);
    for (int n = 0; n < 8; n++) send1(1, 32768);
    for (int n = 0; n < 8; n++) send1(1, 32767);

    repeat (4) edge_go();
    check_eq("drain1", exp_q0.size(), 0);
    check_eq("drain2", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
